// File: rtl/dmx_pkg.sv
// Shared opcodes, command-word field positions and reset constants for the
// dot-matrix scan controller.
package dmx_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SET_PTR   = 3'd1;
  localparam logic [2:0] OP_WRITE_COL = 3'd2;
  localparam logic [2:0] OP_SHL       = 3'd3;
  localparam logic [2:0] OP_SHR       = 3'd4;
  localparam logic [2:0] OP_CLEAR     = 3'd5;
  localparam logic [2:0] OP_BRIGHT    = 3'd6;
  localparam logic [2:0] OP_CTRL      = 3'd7;

  localparam int unsigned OpMsb   = 15;
  localparam int unsigned OpLsb   = 13;
  localparam int unsigned ArgMsb  = 12;
  localparam int unsigned ArgLsb  = 8;
  localparam int unsigned BlankBit = 0;
  localparam int unsigned SwapBit  = 1;

  localparam logic [2:0] DutyReset = 3'd7;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmx_scan_timer.sv
// Row scan timing: slot counter, row index, PWM lit window and a registered
// flag marking the first cycle of a new frame.
module dmx_scan_timer
  import dmx_pkg::*;
#(
  parameter int unsigned ROWS      = 7,
  parameter int unsigned SLOT_LOG2 = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2:0]               duty_i,
  output logic [idx_w(ROWS)-1:0]   row_o,
  output logic                     lit_o,
  output logic                     wrap_o
);

  localparam int unsigned RowW = idx_w(ROWS);

  logic [SLOT_LOG2-1:0] cnt_q;
  logic [RowW-1:0]      row_q, row_d;
  logic                 wrap_q;
  logic                 slot_end, last_row;

  assign slot_end = &cnt_q;
  assign last_row = (row_q == RowW'(ROWS - 1));

  always_comb begin
    row_d = row_q;
    if (slot_end) begin
      row_d = last_row ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      row_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      row_q  <= row_d;
      wrap_q <= slot_end & last_row;
    end
  end

  assign row_o  = row_q;
  // Top three counter bits against duty: duty 0 lights 1/8 of the slot.
  assign lit_o  = (cnt_q[SLOT_LOG2-1 -: 3] <= duty_i);
  assign wrap_o = wrap_q;

endmodule

// File: rtl/dmx_scan_ctrl.sv
// Dot-matrix display controller: bus-written frame buffer multiplexed onto
// one-hot rows and active-low columns. Define DMX_DBUF_EN for double buffering.
module dmx_scan_ctrl
  import dmx_pkg::*;
#(
  parameter int unsigned ROWS      = 7,
  parameter int unsigned COLS      = 30,
  parameter int unsigned ROW_REP   = 6,
  parameter int unsigned SLOT_LOG2 = 16,
  parameter logic [15:0] DEV_ADDR  = 16'h0040
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               DEVICE,
  input  logic [15:0]               DATA,
  input  logic                      wr,
  output logic [ROWS*ROW_REP-1:0]   row_out,
  output logic [COLS-1:0]           col_out,
  output logic                      frame_sync
);

  localparam int unsigned RowW = idx_w(ROWS);
  localparam int unsigned PtrW = idx_w(COLS);

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  logic [RowW-1:0] row;
  logic            lit, wrap;
  logic            cmd_en;
  logic [2:0]      op;
  logic [4:0]      arg;
  logic [ROWS-1:0] pay;
  logic            unused_data;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [2:0]      duty_q, duty_d;
  logic            blank_q, blank_d;
  frame_t          back_cur, back_nxt, disp_fb;

  logic [ROWS*ROW_REP-1:0] row_out_q, row_out_d;
  logic [COLS-1:0]         col_out_q, col_out_d;
  logic                    frame_sync_q;
  logic [ROWS-1:0]         onehot;

  dmx_scan_timer #(
    .ROWS      (ROWS),
    .SLOT_LOG2 (SLOT_LOG2)
  ) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .duty_i (duty_q),
    .row_o  (row),
    .lit_o  (lit),
    .wrap_o (wrap)
  );

  assign cmd_en      = wr && (DEVICE == DEV_ADDR);
  assign op          = DATA[OpMsb:OpLsb];
  assign arg         = DATA[ArgMsb:ArgLsb];
  assign pay         = DATA[ROWS-1:0];
  assign unused_data = ^DATA;

  always_comb begin
    back_nxt = back_cur;
    ptr_d    = ptr_q;
    duty_d   = duty_q;
    blank_d  = blank_q;
    if (cmd_en) begin
      case (op)
        OP_SET_PTR: begin
          if (32'(arg) < COLS) ptr_d = arg[PtrW-1:0];
        end
        OP_WRITE_COL: begin
          for (int r = 0; r < ROWS; r++) back_nxt[r][ptr_q] = pay[r];
          ptr_d = (ptr_q == PtrW'(COLS - 1)) ? '0 : ptr_q + 1'b1;
        end
        OP_SHL: begin
          for (int r = 0; r < ROWS; r++) back_nxt[r] = {back_cur[r][COLS-2:0], pay[r]};
        end
        OP_SHR: begin
          for (int r = 0; r < ROWS; r++) back_nxt[r] = {pay[r], back_cur[r][COLS-1:1]};
        end
        OP_CLEAR: begin
          back_nxt = '0;
          ptr_d    = '0;
        end
        OP_BRIGHT: duty_d  = DATA[2:0];
        OP_CTRL:   blank_d = DATA[BlankBit];
        default: ;
      endcase
    end
  end

`ifdef DMX_DBUF_EN
  frame_t fb_q [2];
  frame_t fb_d [2];
  logic   front_q, front_d, pend_q, pend_d, swap;

  assign swap     = pend_q & wrap;
  assign front_d  = front_q ^ swap;
  // Writes always target the pre-swap back buffer, even in the swap cycle.
  assign back_cur = fb_q[~front_q];
  assign disp_fb  = fb_q[front_d];

  always_comb begin
    fb_d            = fb_q;
    fb_d[~front_q]  = back_nxt;
    pend_d          = pend_q;
    if (swap) pend_d = 1'b0;
    if (cmd_en && (op == OP_CTRL) && DATA[SwapBit]) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_q    <= '{default: '0};
      front_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      fb_q    <= fb_d;
      front_q <= front_d;
      pend_q  <= pend_d;
    end
  end
`else
  frame_t fb_q;

  assign back_cur = fb_q;
  assign disp_fb  = fb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_q <= '0;
    end else begin
      fb_q <= back_nxt;
    end
  end
`endif

  always_comb begin
    onehot      = '0;
    onehot[row] = 1'b1;
    row_out_d   = '0;
    col_out_d   = '1;
    if (lit && !blank_q) begin
      row_out_d = {ROW_REP{onehot}};
      col_out_d = ~disp_fb[row];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      duty_q       <= DutyReset;
      blank_q      <= 1'b0;
      row_out_q    <= '0;
      col_out_q    <= '1;
      frame_sync_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      duty_q       <= duty_d;
      blank_q      <= blank_d;
      row_out_q    <= row_out_d;
      col_out_q    <= col_out_d;
      frame_sync_q <= wrap;
    end
  end

  assign row_out    = row_out_q;
  assign col_out    = col_out_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_dmx_scan_ctrl.sv
// Directed bench for dmx_scan_ctrl with a short scan slot (8 cycles per row).
module tb_dmx_scan_ctrl;

  localparam int ROWS = 7;
  localparam int COLS = 30;
  localparam int REP  = 6;
  localparam int SL   = 3;
  localparam logic [15:0] DEV = 16'h0040;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [15:0]          dev, data;
  logic                 wr;
  logic [ROWS*REP-1:0]  row_out;
  logic [COLS-1:0]      col_out;
  logic                 frame_sync;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmx_scan_ctrl #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ROW_REP   (REP),
    .SLOT_LOG2 (SL),
    .DEV_ADDR  (DEV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .DEVICE     (dev),
    .DATA       (data),
    .wr         (wr),
    .row_out    (row_out),
    .col_out    (col_out),
    .frame_sync (frame_sync)
  );

  typedef struct {
    logic [15:0]     data;
    logic [15:0]     dev;
    logic            wr;
    int              row;
    logic [COLS-1:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic logic [ROWS*REP-1:0] rowvec(int r);
    logic [ROWS*REP-1:0] v;
    v = '0;
    for (int i = 0; i < REP; i++) v[i*ROWS+r] = 1'b1;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmd(logic [15:0] d, logic [15:0] a = DEV, logic w = 1'b1);
    @(negedge clk);
    dev  = a;
    data = d;
    wr   = w;
    @(negedge clk);
    wr   = 1'b0;
    dev  = '0;
    data = '0;
  endtask

  // Wait for row r to be driven, then compare its columns (active low).
  task automatic check_row(string name, int r, logic [COLS-1:0] exp);
    bit              seen;
    logic [COLS-1:0] e;
    seen = 1'b0;
    e    = ~exp;
    @(negedge clk);
    for (int i = 0; i < 80 && !seen; i++) begin
      if (row_out === rowvec(r)) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk({name, " timeout"}, 64'(row_out), 64'(rowvec(r)));
    else       chk(name, 64'(col_out), 64'(e));
  endtask

  task automatic count_lit(string name, int exp);
    int n;
    n = 0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 56; i++) begin
      if (row_out != '0) n++;
      @(negedge clk);
    end
    chk(name, 64'(n), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    wr   = 1'b0;
    dev  = '0;
    data = '0;
    #23;
    chk("reset row_out", 64'(row_out), 64'd0);
    chk("reset col_out", 64'(col_out), 64'h3FFF_FFFF);
    chk("reset frame_sync", 64'(frame_sync), 64'd0);

    // Free run: row steps every 8 cycles, frame_sync every 56.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      chk($sformatf("freerun k=%0d row_out", k), 64'(row_out), 64'(rowvec(((k - 1) / 8) % 7)));
      chk($sformatf("freerun k=%0d frame_sync", k), 64'(frame_sync),
          64'((k > 1) && ((k - 1) % 56 == 0)));
      chk($sformatf("freerun k=%0d col_out", k), 64'(col_out), 64'h3FFF_FFFF);
    end

`ifndef DMX_DBUF_EN
    vt.push_back('{16'hA000, DEV,      1'b1, 0, 30'h0000_0000});
    vt.push_back('{16'h3D00, DEV,      1'b1, 0, 30'h0000_0000});
    vt.push_back('{16'h407F, DEV,      1'b1, 3, 30'h2000_0000});
    vt.push_back('{16'h407F, DEV,      1'b1, 6, 30'h2000_0001});
    vt.push_back('{16'h4005, DEV,      1'b1, 2, 30'h2000_0003});
    vt.push_back('{16'h0000, DEV,      1'b1, 1, 30'h2000_0001});
    vt.push_back('{16'h3E00, DEV,      1'b1, 0, 30'h2000_0003});
    vt.push_back('{16'h4001, DEV,      1'b1, 0, 30'h2000_0007});
    vt.push_back('{16'h6001, DEV,      1'b1, 2, 30'h0000_0006});
    vt.push_back('{16'h8002, DEV,      1'b1, 0, 30'h0000_0007});
    vt.push_back('{16'h0000, DEV,      1'b1, 1, 30'h2000_0001});
    vt.push_back('{16'h0000, DEV,      1'b1, 2, 30'h0000_0003});
    vt.push_back('{16'h407F, 16'h0041, 1'b1, 4, 30'h0000_0001});
    vt.push_back('{16'h407F, DEV,      1'b0, 5, 30'h0000_0001});
    vt.push_back('{16'h4010, DEV,      1'b1, 4, 30'h0000_0009});
    foreach (vt[i]) begin
      cmd(vt[i].data, vt[i].dev, vt[i].wr);
      check_row($sformatf("vec%0d row%0d", i, vt[i].row), vt[i].row, vt[i].exp);
    end

    // 31 left shifts of a row-0 pixel: the first one falls off column 29.
    cmd(16'hA000);
    for (int i = 0; i < 31; i++) cmd(16'h6001);
    check_row("shl31 row0", 0, 30'h3FFF_FFFF);
    check_row("shl31 row1", 1, 30'h0000_0000);
`else
    // Write lands in back buffer; display follows only after the frame swap.
    begin
      int  bad;
      bit  got;
      logic [COLS-1:0] e;
      cmd(16'h4001);
      check_row("dbuf pre-swap row0", 0, 30'h0);
      cmd(16'hE002);
      bad = 0;
      got = 1'b0;
      for (int i = 0; i < 120 && !got; i++) begin
        @(negedge clk);
        if (frame_sync) got = 1'b1;
        else if (col_out !== '1) bad++;
      end
      chk("dbuf display before sync", 64'(bad), 64'd0);
      chk("dbuf frame_sync seen", 64'(got), 64'd1);
      e = ~30'h1;
      chk("dbuf swap row_out", 64'(row_out), 64'(rowvec(0)));
      chk("dbuf swap col_out", 64'(col_out), 64'(e));
      cmd(16'hA000);
      check_row("dbuf clear hits back only", 0, 30'h1);
    end
`endif

    cmd(16'hC000);
    count_lit("duty0 lit cycles", 7);
    cmd(16'hC003);
    count_lit("duty3 lit cycles", 28);
    cmd(16'hC007);
    count_lit("duty7 lit cycles", 56);
    cmd(16'hE001);
    chk("blank not yet applied", 64'(row_out != '0), 64'd1);
    count_lit("blank lit cycles", 0);
    cmd(16'hE000);
    count_lit("unblank lit cycles", 56);

    // Asynchronous reset mid-slot with data loaded on row 0.
    cmd(16'h3D00);
    cmd(16'h4001);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst row_out", 64'(row_out), 64'd0);
    chk("async rst col_out", 64'(col_out), 64'h3FFF_FFFF);
    chk("async rst frame_sync", 64'(frame_sync), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst row0", 64'(row_out), 64'(rowvec(0)));
    chk("post rst buffer cleared", 64'(col_out), 64'h3FFF_FFFF);
    repeat (8) @(negedge clk);
    chk("post rst row1", 64'(row_out), 64'(rowvec(1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmx_scan_ctrl.md
# dmx_scan_ctrl

Parametrised dot-matrix display controller, the successor of the fixed 7x30 matrix driver on device address 0x0040. It holds a ROWS x COLS frame buffer written through the DEVICE/DATA peripheral bus using an opcode/pointer command set. It multiplexes the buffer onto one-hot row lines and active-low column lines, with brightness PWM, blanking and optional double buffering. It sits on the peripheral bus beside the other DEVICE-decoded blocks and drives the LED matrix pins directly.

## Interface
- ROWS, 7, matrix rows; legal range 1..8
- COLS, 30, matrix columns; legal range 2..32
- ROW_REP, 6, replication factor of the row vector on row_out (one copy per cascaded module)
- SLOT_LOG2, 16, log2 of clk cycles per row scan slot; legal range 3 or more
- DEV_ADDR, 16'h0040, DEVICE value that selects this block
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- DEVICE  in  16  device select bus
- DATA  in  16  command word
- wr  in  1  write strobe; a command executes once per cycle with wr=1 and DEVICE==DEV_ADDR
- row_out  out  ROWS*ROW_REP  active-high one-hot row drive, replicated ROW_REP times
- col_out  out  COLS  active-low column drive for the current row
- frame_sync  out  1  one-cycle pulse when the scan wraps from row ROWS-1 to row 0

## Operation
- Command word fields: opcode DATA[15:13], argument DATA[12:8], pixel payload DATA[ROWS-1:0] (bit r is row r).
- Opcode 0, NOP: no effect.
- Opcode 1, SET_PTR: ptr <= DATA[12:8] when the argument is less than COLS; otherwise the command is ignored.
- Opcode 2, WRITE_COL: column ptr of every row r <= payload[r]; ptr then increments and wraps from COLS-1 to 0.
- Opcode 3, SHIFT_L: every row shifts toward the higher index; column 0 <= payload; column COLS-1 is discarded; ptr is unchanged.
- Opcode 4, SHIFT_R: every row shifts toward the lower index; column COLS-1 <= payload; column 0 is discarded.
- Opcode 5, CLEAR: all buffer bits <= 0; ptr <= 0.
- Opcode 6, BRIGHT: duty <= DATA[2:0].
- Opcode 7, CTRL: blank <= DATA[0]; DATA[1]=1 requests a buffer swap (only with DMX_DBUF_EN, see Configuration).
- Scan: slot counter of SLOT_LOG2 bits runs continuously. When the counter reaches all-ones, row index advances 0..ROWS-1 and then wraps.
- PWM: the row is lit while counter[SLOT_LOG2-1 -: 3] <= duty. Duty 7 means fully on; duty 0 means lit for 1/8 of the slot.
- Outputs, registered every cycle:
  - When lit and not blanked: row_out = {ROW_REP{onehot(row)}} and col_out = ~display_row.
  - Otherwise: row_out = 0 and col_out = all ones.
- Reset values:
  - row_out=0, col_out=all ones, frame_sync=0.
  - Buffers all 0; ptr=0; row=0; slot counter=0; duty=7; blank=0; swap pending=0; front buffer = 0.

## Timing
- A command is applied at the rising edge where it is sampled. Its effect on col_out is visible one cycle later if that row is currently displayed.
- Output latency is one cycle from the scan counter and row state.
- frame_sync is asserted in the cycle after row ROWS-1 ends, together with row_out showing row 0.
- Back-to-back writes execute every cycle with no stall, since there is no busy signal.
- A WRITE_COL sampled with ptr=COLS-1 writes column COLS-1 and leaves ptr=0.
- rst asserted mid-slot forces all reset values immediately (asynchronous). Scanning restarts at row 0, slot count 0.
- Blank change takes effect on the next output register update.

## Configuration
- DMX_DBUF_EN defined: two frame buffers, front (displayed) and back (written).
  - CTRL with DATA[1]=1 sets swap pending.
  - The swap occurs at the next frame boundary, in the same cycle as frame_sync; pending then clears.
  - A write in the swap cycle lands in the pre-swap back buffer, which becomes the front buffer.
  - CLEAR affects the back buffer only.
- DMX_DBUF_EN undefined: a single buffer that is both written and displayed; DATA[1] of CTRL is ignored.

## Structure
- Package dmx_pkg holds:
  - opcode localparams: OP_NOP, OP_SET_PTR, OP_WRITE_COL, OP_SHL, OP_SHR, OP_CLEAR, OP_BRIGHT, OP_CTRL;
  - command field position constants;
  - the reset duty constant (7).
- Sub-module dmx_scan_timer contains the slot counter, row index, PWM compare and frame_sync generation. It outputs row index, lit and frame boundary to the top.

## Test plan
- Reset, then free-run with SLOT_LOG2=3 -> row_out steps one-hot through rows 0..6 every 8 cycles; col_out stays all ones; frame_sync pulses every 56 cycles.
- SET_PTR 29, then WRITE_COL 0x7F twice -> column 29 and column 0 are set; ptr=1; col_out bits 29 and 0 are low on every row.
- SHIFT_L with payload 0x01 repeated 31 times, COLS=30 -> only columns 0..29 of row 0 are set; the first pixel has been discarded.
- BRIGHT 0 with SLOT_LOG2=3 -> row_out is nonzero for exactly 1 of 8 cycles per slot. CTRL blank=1 -> row_out is 0 continuously.
- With DMX_DBUF_EN: WRITE_COL to back buffer, request swap -> display unchanged until frame_sync, new data shown from row 0 of the next frame.
- Assert rst mid-slot with data loaded -> outputs return to reset values within the same cycle; the buffer reads back cleared.
